// File: rtl/rd_empty_ctrl.sv
// Read-side pointer/status controller for a dual-clock gray-pointer FIFO.
// Syncs the write gray pointer into rd_clk and tracks read pointer, empty, level and underflow.
module rd_empty_ctrl #(
  parameter int ADDR_SIZE = 4,
  parameter int AE_THRESH = 2
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 rd_inc,
  input  logic                 rd_clr_err,
  input  logic [ADDR_SIZE:0]   rd_wptr,
  output logic                 rd_empty,
  output logic                 rd_almost_empty,
  output logic [ADDR_SIZE-1:0] rd_addr,
  output logic [ADDR_SIZE:0]   rd_ptr,
  output logic [ADDR_SIZE:0]   rd_level,
  output logic                 rd_underflow
);

  localparam int PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  logic [PW-1:0] wq1_q, wq2_q;
  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] wbin_sync;
  logic          empty_q, empty_d;
  logic          ae_q, ae_d;
  logic          uflow_q, uflow_d;
  logic          take;

  // Gray-to-binary of the synchronized write pointer: XOR prefix from the MSB down.
  always_comb begin
    wbin_sync = '0;
    wbin_sync[PW-1] = wq2_q[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      wbin_sync[i] = wbin_sync[i+1] ^ wq2_q[i];
    end
  end

  always_comb begin
    take    = rd_inc & ~empty_q;
    bin_d   = bin_q + {{(PW-1){1'b0}}, take};
    ptr_d   = (bin_d >> 1) ^ bin_d;
    empty_d = (ptr_d == wq2_q);
    level_d = wbin_sync - bin_d;
    ae_d    = (level_d <= AE_T);
    // A fresh underflow beats a simultaneous clear.
    uflow_d = (rd_inc & empty_q) | (uflow_q & ~rd_clr_err);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      wq1_q   <= '0;
      wq2_q   <= '0;
      bin_q   <= '0;
      ptr_q   <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      uflow_q <= 1'b0;
    end else begin
      wq1_q   <= rd_wptr;
      wq2_q   <= wq1_q;
      bin_q   <= bin_d;
      ptr_q   <= ptr_d;
      level_q <= level_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
      uflow_q <= uflow_d;
    end
  end

  assign rd_empty        = empty_q;
  assign rd_almost_empty = ae_q;
  assign rd_addr         = bin_q[ADDR_SIZE-1:0];
  assign rd_ptr          = ptr_q;
  assign rd_level        = level_q;
  assign rd_underflow    = uflow_q;

endmodule

// File: tb/tb_rd_empty_ctrl.sv
// Bench for rd_empty_ctrl: directed scenarios with literal checks, then random traffic
// compared every cycle against a count-based behavioural model.
module tb_rd_empty_ctrl;

  localparam int AW  = 4;
  localparam int PW  = AW + 1;
  localparam int MOD = 1 << PW;
  localparam int DEPTH = 1 << AW;
  localparam int AE  = 2;

  logic          rd_clk = 1'b0;
  logic          rd_rst, rd_inc, rd_clr_err;
  logic [PW-1:0] rd_wptr;
  logic          rd_empty, rd_almost_empty, rd_underflow;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_ptr, rd_level;

  rd_empty_ctrl #(.ADDR_SIZE(AW), .AE_THRESH(AE)) dut (
    .rd_clk          (rd_clk),
    .rd_rst          (rd_rst),
    .rd_inc          (rd_inc),
    .rd_clr_err      (rd_clr_err),
    .rd_wptr         (rd_wptr),
    .rd_empty        (rd_empty),
    .rd_almost_empty (rd_almost_empty),
    .rd_addr         (rd_addr),
    .rd_ptr          (rd_ptr),
    .rd_level        (rd_level),
    .rd_underflow    (rd_underflow)
  );

  always #5 rd_clk = ~rd_clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Model state: counts and delayed samples, not register images.
  int m_q1, m_q2, m_rc, m_level, m_uf;
  bit m_empty;
  int wcnt;

  function automatic int g2b(input int g);
    int b = 0;
    for (int s = 0; s < PW; s++) b ^= (g >> s);
    return b & (MOD - 1);
  endfunction

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & (MOD - 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge rd_clk) begin
    int take;
    if (rd_rst) begin
      m_q1 = 0; m_q2 = 0; m_rc = 0; m_level = 0; m_empty = 1; m_uf = 0;
      chk_en = 1;
    end else begin
      take    = (rd_inc && !m_empty) ? 1 : 0;
      m_uf    = ((rd_inc && m_empty) || (m_uf != 0 && !rd_clr_err)) ? 1 : 0;
      m_rc    = (m_rc + take) % MOD;
      m_level = (g2b(m_q2) - m_rc) & (MOD - 1);
      m_empty = (m_level == 0);
      m_q2    = m_q1;
      m_q1    = int'(rd_wptr);
    end
    #1;
    if (chk_en) begin
      chk("m_empty", 32'(rd_empty), 32'(m_empty));
      chk("m_ae", 32'(rd_almost_empty), (m_level <= AE) ? 32'd1 : 32'd0);
      chk("m_ptr", 32'(rd_ptr), 32'(b2g(m_rc)));
      chk("m_addr", 32'(rd_addr), 32'(m_rc % DEPTH));
      chk("m_level", 32'(rd_level), 32'(m_level));
      chk("m_uflow", 32'(rd_underflow), 32'(m_uf));
    end
  end

  task automatic cyc(input logic inc, input logic clr);
    rd_inc = inc;
    rd_clr_err = clr;
    @(negedge rd_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, 32'(rd_empty), 32'd1);
    chk({tag, "_ae"}, 32'(rd_almost_empty), 32'd1);
    chk({tag, "_ptr"}, 32'(rd_ptr), 32'd0);
    chk({tag, "_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_level"}, 32'(rd_level), 32'd0);
    chk({tag, "_uflow"}, 32'(rd_underflow), 32'd0);
  endtask

  initial begin
    rd_rst = 1'b1; rd_inc = 1'b0; rd_clr_err = 1'b0; rd_wptr = 5'b00011;
    @(negedge rd_clk);
    @(negedge rd_clk);
    rd_rst = 1'b0; rd_wptr = '0;
    chk_reset_vals("rst");

    // Sync latency: one entry becomes visible on the third edge.
    rd_wptr = 5'b00001;
    idle(1); chk("lat_k", 32'(rd_empty), 32'd1);
    idle(1); chk("lat_k1", 32'(rd_empty), 32'd1);
    idle(1);
    chk("lat_k2_empty", 32'(rd_empty), 32'd0);
    chk("lat_k2_level", 32'(rd_level), 32'd1);
    chk("lat_k2_ae", 32'(rd_almost_empty), 32'd1);

    // Full drain from 16 entries.
    rd_wptr = 5'b11000;
    idle(3);
    chk("drain_level16", 32'(rd_level), 32'd16);
    chk("drain_ae0", 32'(rd_almost_empty), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("drain_addr", 32'(rd_addr), 32'(i));
      cyc(1'b1, 1'b0);
      chk("drain_level", 32'(rd_level), 32'(15 - i));
      chk("drain_ae", 32'(rd_almost_empty), (15 - i <= AE) ? 32'd1 : 32'd0);
    end
    rd_inc = 1'b0;
    chk("drain_empty", 32'(rd_empty), 32'd1);
    chk("drain_ptr", 32'(rd_ptr), 32'b11000);

    // Second lap wraps the pointer back to zero.
    rd_wptr = 5'b00000;
    idle(3);
    chk("wrap_level16", 32'(rd_level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("wrap_addr", 32'(rd_addr), 32'(i));
      cyc(1'b1, 1'b0);
      if (i == 14) chk("wrap_ptr31", 32'(rd_ptr), 32'b10000);
    end
    rd_inc = 1'b0;
    chk("wrap_ptr0", 32'(rd_ptr), 32'd0);
    chk("wrap_empty", 32'(rd_empty), 32'd1);
    chk("wrap_uflow", 32'(rd_underflow), 32'd0);

    // Underflow set, clear-collision, then clear.
    cyc(1'b1, 1'b0);
    chk("uf_set", 32'(rd_underflow), 32'd1);
    chk("uf_ptr", 32'(rd_ptr), 32'd0);
    cyc(1'b1, 1'b1);
    chk("uf_collide", 32'(rd_underflow), 32'd1);
    cyc(1'b0, 1'b1);
    chk("uf_clear", 32'(rd_underflow), 32'd0);
    rd_clr_err = 1'b0;

    // Reset in the middle of a drain.
    rd_wptr = 5'b00111;
    idle(3);
    chk("mid_level5", 32'(rd_level), 32'd5);
    rd_rst = 1'b1;
    cyc(1'b1, 1'b0);
    chk_reset_vals("mid_rst");
    rd_rst = 1'b0;
    idle(3);
    chk("mid_refill", 32'(rd_level), 32'd5);

    // Random traffic with a well-behaved gray write pointer.
    wcnt = 5;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0 && ((wcnt - m_rc) & (MOD - 1)) < DEPTH) wcnt++;
      rd_rst = ($urandom_range(0, 199) == 0);
      if (rd_rst) wcnt = 0;
      rd_wptr = PW'(b2g(wcnt & (MOD - 1)));
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end
    rd_rst = 1'b0; rd_inc = 1'b0; rd_clr_err = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
